// File: rtl/aes_round_ctrl_if.sv
// Handshake and round-datapath bundle for the iterative AES sequencer.
// slave  : the sequencer's view (drives state, key index, handshakes).
// master : the environment's view (plaintext source, key store, datapath, sink).
interface aes_round_ctrl_if #(
  parameter int RW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_block;
  logic [RW-1:0] rk_idx;
  logic [127:0]  rk;
  logic [127:0]  dp_state;
  logic          dp_last;
  logic [127:0]  dp_result;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_block;
  logic          busy;
  logic [RW-1:0] round;

  modport slave (
    input  in_valid, in_block, rk, dp_result, out_ready,
    output in_ready, rk_idx, dp_state, dp_last, out_valid, out_block, busy, round
  );

  modport master (
    output in_valid, in_block, rk, dp_result, out_ready,
    input  in_ready, rk_idx, dp_state, dp_last, out_valid, out_block, busy, round
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: holds the 128-bit state and round
// counter, whitens the accepted block with round key 0, then feeds the shared
// combinational round datapath once per cycle for NR rounds. The final round
// is flagged so the datapath skips mixColumns.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic            clk,
  input  logic            rst,
  aes_round_ctrl_if.slave bus
);

  // Only AES-128/192/256 round counts make sense, and the counter must hold NR.
  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end
  if ((1 << RW) <= NR) begin : g_bad_rw
    $error("aes_round_ctrl: RW too narrow for NR");
  end

  localparam logic [RW-1:0] LAST_RND = RW'(NR);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [127:0]  blk_q,   blk_d;

  // State register: reset clears FSM, counter and the block register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      blk_q   <= blk_d;
    end
  end

  // Next-state: capture/whiten in IDLE, iterate in ROUND, wait for sink in DONE.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    blk_d   = blk_q;
    case (state_q)
      S_IDLE: begin
        // rk_idx is 0 here, so rk is the whitening key.
        if (bus.in_valid) begin
          blk_d   = bus.in_block ^ bus.rk;
          round_d = RW'(1);
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        blk_d = bus.dp_result;
        if (round_q == LAST_RND) begin
          round_d = '0;
          state_d = S_DONE;
        end else begin
          round_d = round_q + RW'(1);
        end
      end
      S_DONE: begin
        // Ciphertext stays in blk_q after the handoff; only the FSM moves.
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        round_d = '0;
      end
    endcase
  end

  // Outputs: pure decode of the registered state (plus rst gating in_ready).
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE) && !rst;
    bus.rk_idx    = (state_q == S_ROUND) ? round_q : '0;
    bus.dp_last   = (state_q == S_ROUND) && (round_q == LAST_RND);
    bus.dp_state  = blk_q;
    bus.out_valid = (state_q == S_DONE);
    bus.out_block = blk_q;
    bus.busy      = (state_q != S_IDLE);
    bus.round     = round_q;
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: behavioural AES round datapath and key
// schedule, two DUTs (NR=10 and NR=14) sharing one stimulus path via sel,
// and a scoreboard queue of expected ciphertexts.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, sel, in_valid, out_ready;
  logic [127:0] in_block;
  int           cyc = 0;
  int           nr, acc_cyc, n_vec, n_bad;
  logic [127:0] sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  aes_round_ctrl_if #(.RW(4)) if10 ();
  aes_round_ctrl_if #(.RW(4)) if14 ();

  aes_round_ctrl #(.NR(10), .RW(4)) u_dut10 (.clk(clk), .rst(rst), .bus(if10));
  aes_round_ctrl #(.NR(14), .RW(4)) u_dut14 (.clk(clk), .rst(rst), .bus(if14));

  logic [127:0] ks [0:15];
  logic [127:0] rk10 [0:15];
  logic [127:0] rk14 [0:15];

  // ---------------- AES reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++)
      if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k,
                                              input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nrr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nrr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nrr; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input int nrr);
    logic [127:0] s;
    s = pt ^ ks[0];
    for (int r = 1; r <= nrr; r++) s = aes_round(s, ks[r], r == nrr);
    return s;
  endfunction

  // ---------------- environment wiring ----------------
  assign if10.in_valid  = in_valid & ~sel;
  assign if14.in_valid  = in_valid & sel;
  assign if10.in_block  = in_block;
  assign if14.in_block  = in_block;
  assign if10.out_ready = out_ready & ~sel;
  assign if14.out_ready = out_ready & sel;
  assign if10.rk        = rk10[if10.rk_idx];
  assign if14.rk        = rk14[if14.rk_idx];
  assign if10.dp_result = aes_round(if10.dp_state, if10.rk, if10.dp_last);
  assign if14.dp_result = aes_round(if14.dp_state, if14.rk, if14.dp_last);

  logic         o_in_ready, o_out_valid, o_dp_last, o_busy;
  logic [3:0]   o_rk_idx, o_round;
  logic [127:0] o_out_block;
  assign o_in_ready  = sel ? if14.in_ready  : if10.in_ready;
  assign o_out_valid = sel ? if14.out_valid : if10.out_valid;
  assign o_dp_last   = sel ? if14.dp_last   : if10.dp_last;
  assign o_busy      = sel ? if14.busy      : if10.busy;
  assign o_rk_idx    = sel ? if14.rk_idx    : if10.rk_idx;
  assign o_round     = sel ? if14.round     : if10.round;
  assign o_out_block = sel ? if14.out_block : if10.out_block;

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer a block until accepted; push its expected ciphertext.
  task automatic accept(input logic [127:0] blk, input logic [127:0] exp, input bit keep);
    int n;
    in_block = blk;
    in_valid = 1'b1;
    n = 0;
    while (o_in_ready !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chki("accept_ready", int'(o_in_ready), 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    sbq.push_back(exp);
    if (!keep) in_valid = 1'b0;
  endtask

  // Follow the rounds: key index, last flag and latency to out_valid.
  task automatic wait_done(input bit keep);
    int k;
    for (int n = 0; n < 40 && o_out_valid !== 1'b1; n++) begin
      k = cyc - acc_cyc;
      chki("round_rk_idx", int'(o_rk_idx), k + 1);
      chki("round_dp_last", int'(o_dp_last), int'(k + 1 == nr));
      chki("round_in_ready", int'(o_in_ready), 0);
      if (keep) in_block = rnd128();
      @(posedge clk); #1;
    end
    chki("out_valid_rise", int'(o_out_valid), 1);
    chki("latency", cyc - acc_cyc, nr);
    chki("done_rk_idx", int'(o_rk_idx), 0);
    chki("done_dp_last", int'(o_dp_last), 0);
    chki("done_busy", int'(o_busy), 1);
  endtask

  // Optionally stall the sink, then take the ciphertext and compare.
  task automatic handoff(input int hold);
    logic [127:0] held, exp;
    held = o_out_block;
    for (int i = 0; i < hold; i++) begin
      chki("hold_out_valid", int'(o_out_valid), 1);
      chk("hold_out_block", o_out_block, held);
      chki("hold_in_ready", int'(o_in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chki("done_in_ready", int'(o_in_ready), 0);
    chki("sb_nonempty", int'(sbq.size() != 0), 1);
    exp = (sbq.size() != 0) ? sbq.pop_front() : '0;
    chk("ciphertext", o_out_block, exp);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chki("post_out_valid", int'(o_out_valid), 0);
    chki("post_busy", int'(o_busy), 0);
    chki("post_in_ready", int'(o_in_ready), 1);
    chk("post_state_kept", o_out_block, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] pa, pb;
    int t0;
    n_vec = 0; n_bad = 0; acc_cyc = 0;
    for (int i = 0; i < 16; i++) begin ks[i] = '0; rk10[i] = '0; rk14[i] = '0; end
    rst = 1'b1; sel = 1'b0; nr = 10; in_valid = 1'b0; out_ready = 1'b0; in_block = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chki("rst_in_ready", int'(o_in_ready), 0);
    chki("rst_out_valid", int'(o_out_valid), 0);
    chki("rst_busy", int'(o_busy), 0);
    chki("rst_dp_last", int'(o_dp_last), 0);
    chki("rst_rk_idx", int'(o_rk_idx), 0);
    chki("rst_round", int'(o_round), 0);
    chk("rst_out_block", o_out_block, 128'h0);
    chki("rst14_busy", int'(if14.busy), 0);
    rst = 1'b0;
    #1;
    chki("rel_in_ready", int'(o_in_ready), 1);

    // FIPS-197 C.1, AES-128.
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    for (int i = 0; i < 16; i++) rk10[i] = ks[i];
    accept(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
    wait_done(1'b0);
    handoff(0);

    // FIPS-197 B, then 5-cycle sink stall with a pending block offered.
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    for (int i = 0; i < 16; i++) rk10[i] = ks[i];
    accept(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 1'b0);
    wait_done(1'b0);
    t0 = acc_cyc;
    pa = rnd128();
    in_block = pa;
    in_valid = 1'b1;
    handoff(5);
    accept(pa, aes_enc(pa, 10), 1'b0);
    chki("bp_accept_gap", acc_cyc - t0, 10 + 2 + 5);
    wait_done(1'b0);
    handoff(0);

    // in_valid held with changing data during rounds: no recapture.
    pa = rnd128();
    accept(pa, aes_enc(pa, 10), 1'b1);
    wait_done(1'b1);
    t0 = acc_cyc;
    pb = rnd128();
    in_block = pb;
    handoff(0);
    accept(pb, aes_enc(pb, 10), 1'b0);
    chki("min_accept_gap", acc_cyc - t0, 10 + 2);
    wait_done(1'b0);
    handoff(0);

    // Reset at round 5 aborts the block.
    pa = rnd128();
    accept(pa, aes_enc(pa, 10), 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chki("pre_abort_round", int'(o_round), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chki("abort_in_ready", int'(o_in_ready), 1);
    chki("abort_out_valid", int'(o_out_valid), 0);
    chki("abort_busy", int'(o_busy), 0);
    chki("abort_round", int'(o_round), 0);
    if (sbq.size() != 0) void'(sbq.pop_back());
    pb = rnd128();
    accept(pb, aes_enc(pb, 10), 1'b0);
    wait_done(1'b0);
    handoff(0);

    // FIPS-197 C.3, AES-256 on the NR=14 instance.
    sel = 1'b1;
    nr = 14;
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    for (int i = 0; i < 16; i++) rk14[i] = ks[i];
    #1;
    chki("nr14_idle_ready", int'(o_in_ready), 1);
    accept(128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 1'b0);
    wait_done(1'b0);
    handoff(0);

    chki("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Backstop in case a bounded loop logic error lets the run stall.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES encryption sequencer. Owns the 128-bit state register and round counter, and drives one shared combinational round datapath (subBytes -> shiftRows -> mixColumns -> addRoundKey) once per cycle. It performs the initial key whitening, runs NR rounds, and suppresses mixColumns in the final round. Round keys come from an external key-schedule store indexed by this block; blocks are accepted and delivered on valid/ready handshakes.

Parameters:
NR, 10, number of rounds; legal values 10/12/14 (AES-128/192/256); any other value is an elaboration error
RW, 4, round-counter and key-index width; must satisfy 2^RW > NR

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  plaintext block offered
in_ready  output  1  block can be accepted this cycle
in_block  input  128  plaintext, same byte/bit layout as the round datapath
rk_idx  output  RW  round-key index requested from the key-schedule store
rk  input  128  round key for rk_idx, combinational, valid in the same cycle
dp_state  output  128  current state register, fed to the round datapath
dp_last  output  1  final round; datapath bypasses mixColumns
dp_result  input  128  combinational round result for dp_state, rk and dp_last
out_valid  output  1  ciphertext available
out_ready  input  1  consumer accepts ciphertext
out_block  output  128  ciphertext (equals dp_state while in DONE)
busy  output  1  high in ROUND or DONE
round  output  RW  current round counter (debug)

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high. With rst high at a rising edge, the block goes to FSM=IDLE, round=0, state reg=0.
- Reset output values: out_valid=0, busy=0, dp_last=0, rk_idx=0, out_block=0. in_ready is 0 while rst is high and 1 on the first cycle after reset is released.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, rk_idx=0.
  - When in_valid=1: state <= in_block ^ rk (key whitening), round <= 1, go to ROUND.
- ROUND:
  - rk_idx=round; dp_last=(round==NR).
  - Each cycle: state <= dp_result, round <= round+1.
  - When round==NR: round <= 0, go to DONE.
  - in_ready=0 for the whole state.
- DONE:
  - out_valid=1; out_block=state; rk_idx=0.
  - When out_ready=1: go to IDLE. The state register keeps its value; out_valid falls on the next cycle.
  - While out_ready=0: out_valid and out_block are held stable indefinitely.
- Latency: if the accept edge is T, out_valid rises after edge T+NR. Minimum block-to-block period is NR+2 cycles (accept, NR rounds, handoff). There is no overlap: in_ready is 0 in the DONE cycle even when out_ready=1.
- dp_last is high for exactly one cycle per block. It never asserts in IDLE or DONE.
- in_valid while busy is ignored: no capture, no error. in_block only needs to be stable in the accept cycle.
- Widths: round never exceeds NR. All XOR and state operations are a full 128 bits with no truncation.
- Reset during ROUND or DONE aborts the block: the FSM returns to IDLE and out_valid=0 after that edge. No ciphertext is emitted for the aborted block.
- rst has priority over all handshakes in the same cycle.

Test Plan:
- NR=10, bench datapath model plus key schedule, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_block=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises exactly 10 cycles after the accept edge; dp_last high only while rk_idx=10.
- NR=10, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; rk_idx sequence 0,1..10.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_block unchanged throughout; in_ready=0; second block accepted only after the handshake and the return to IDLE.
- in_valid held high with varying in_block during rounds 1-10 -> no recapture; ciphertext matches the first block; next accept occurs exactly NR+2 cycles after the first.
- rst pulsed at round=5 -> next cycle FSM IDLE, in_ready=1, out_valid=0, busy=0; a following block encrypts correctly.
- NR=14, key 000102...1e1f, pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089; latency 14 cycles.
